// File: rtl/uart_tx_queue_pkg.sv
// Shared peripheral definitions: UART transmit-queue FSM encoding and sizing constants.
package periph_defines;

  localparam int UART_TXQ_DEPTH  = 8;
  localparam int UART_BAUD_DIV_W = 16;

  // The fourth encoding (2'b11) is illegal and recovers to TXQ_IDLE
  typedef enum logic [1:0] {
    TXQ_IDLE     = 2'd0,
    TXQ_WAIT_ACK = 2'd1,
    TXQ_SENDING  = 2'd2
  } txq_state_e;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Bus-side and transmitter-side signals of the UART transmit queue.
interface uart_tx_queue_if #(
  parameter int DEPTH = 8
) ();

  logic                     wr_en;
  logic [7:0]               wr_data;
  logic                     flush;
  logic                     clr_ovf;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     idle;
  logic                     trmt;
  logic [7:0]               tx_data;
  logic                     tx_ready;

  // master = surrounding system (bus host plus transmitter), slave = the queue
  modport master (
    output wr_en, wr_data, flush, clr_ovf, tx_ready,
    input  full, empty, count, overflow, idle, trmt, tx_data
  );

  modport slave (
    input  wr_en, wr_data, flush, clr_ovf, tx_ready,
    output full, empty, count, overflow, idle, trmt, tx_data
  );

endinterface

// File: rtl/uart_tx_queue_sync_fifo.sv
// Single-clock FIFO: unreset storage, wrapping pointers, count-derived full/empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // A full queue refuses writes even when a pop frees a slot this cycle
  assign w_push  = i_push & ~o_full & ~i_flush;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = (r_count == CNT_MAX);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// UART transmit queue: buffers bus writes and hands bytes to the transmitter one frame at a time.
module uart_tx_queue
  import periph_defines::*;
#(
  parameter int DEPTH = UART_TXQ_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_queue_if.slave  bus
);

  txq_state_e              r_state;
  txq_state_e              w_next;
  logic                    r_overflow;
  logic                    w_trmt;
  logic                    w_drop;
  logic                    w_full;
  logic                    w_empty;
  logic [$clog2(DEPTH):0]  w_count;
  logic [7:0]              w_rdata;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (bus.flush),
    .i_push  (bus.wr_en),
    .i_pop   (w_trmt),
    .i_wdata (bus.wr_data),
    .o_rdata (w_rdata),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A write swallowed by flush is not an overflow
  assign w_drop = bus.wr_en & w_full & ~bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (bus.clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= TXQ_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_trmt = 1'b0;
    case (r_state)
      TXQ_IDLE: begin
        if (!w_empty && bus.tx_ready) begin
          w_trmt = 1'b1;
          w_next = TXQ_WAIT_ACK;
        end
      end
      TXQ_WAIT_ACK: if (!bus.tx_ready) w_next = TXQ_SENDING;
      TXQ_SENDING:  if (bus.tx_ready)  w_next = TXQ_IDLE;
      default:      w_next = TXQ_IDLE;
    endcase
  end

  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.count    = w_count;
  assign bus.overflow = r_overflow;
  assign bus.idle     = w_empty & (r_state == TXQ_IDLE) & bus.tx_ready;
  assign bus.trmt     = w_trmt;
  assign bus.tx_data  = w_rdata;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a hand-driven transmitter ready line.
module tb_uart_tx_queue;
  import periph_defines::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  uart_tx_queue_if #(.DEPTH(8)) bus ();

  uart_tx_queue #(.DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    bus.wr_en = 0; bus.wr_data = 0; bus.flush = 0; bus.clr_ovf = 0; bus.tx_ready = 1;
    rst = 1'b1;
    step(); step();
    vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
    vectors++; if (bus.full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b expected 0", bus.full); end
    vectors++; if (bus.count !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b expected 0", bus.overflow); end
    vectors++; if (bus.trmt !== 1'b0) begin miscompares++; $display("FAIL reset_trmt: got %b expected 0", bus.trmt); end
    vectors++; if (bus.idle !== 1'b1) begin miscompares++; $display("FAIL reset_idle_hi: got %b expected 1", bus.idle); end
    bus.tx_ready = 0; #1;
    vectors++; if (bus.idle !== 1'b0) begin miscompares++; $display("FAIL reset_idle_lo: got %b expected 0", bus.idle); end
    step();
    rst = 1'b0;
    bus.tx_ready = 1;
    step();
  endtask

  task automatic test_single();
    bus.tx_ready = 1;
    push(8'h55);
    #1;
    vectors++; if (bus.trmt !== 1'b1) begin miscompares++; $display("FAIL single_trmt: got %b expected 1", bus.trmt); end
    vectors++; if (bus.tx_data !== 8'h55) begin miscompares++; $display("FAIL single_data: got %h expected 55", bus.tx_data); end
    vectors++; if (bus.count !== 4'd1) begin miscompares++; $display("FAIL single_cnt1: got %0d expected 1", bus.count); end
    step();
    vectors++; if (bus.count !== 4'd0) begin miscompares++; $display("FAIL single_cnt0: got %0d expected 0", bus.count); end
    vectors++; if (dut.r_state !== TXQ_WAIT_ACK) begin miscompares++; $display("FAIL single_wait: got %0d expected %0d", dut.r_state, TXQ_WAIT_ACK); end
    vectors++; if (bus.trmt !== 1'b0) begin miscompares++; $display("FAIL single_trmt_lo: got %b expected 0", bus.trmt); end
    bus.tx_ready = 0;
    step(); step();
    vectors++; if (dut.r_state !== TXQ_SENDING) begin miscompares++; $display("FAIL single_send: got %0d expected %0d", dut.r_state, TXQ_SENDING); end
    bus.tx_ready = 1;
    step();
    vectors++; if (dut.r_state !== TXQ_IDLE) begin miscompares++; $display("FAIL single_idle_st: got %0d expected %0d", dut.r_state, TXQ_IDLE); end
    vectors++; if (bus.idle !== 1'b1) begin miscompares++; $display("FAIL single_idle: got %b expected 1", bus.idle); end
  endtask

  task automatic test_overflow();
    bus.tx_ready = 0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    vectors++; if (bus.full !== 1'b1) begin miscompares++; $display("FAIL ovf_full: got %b expected 1", bus.full); end
    vectors++; if (bus.count !== 4'd8) begin miscompares++; $display("FAIL ovf_cnt8: got %0d expected 8", bus.count); end
    vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_pre: got %b expected 0", bus.overflow); end
    push(8'hFF);
    vectors++; if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b expected 1", bus.overflow); end
    vectors++; if (bus.count !== 4'd8) begin miscompares++; $display("FAIL ovf_cnt_hold: got %0d expected 8", bus.count); end
    bus.clr_ovf = 1;
    push(8'hEE);
    vectors++; if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_clr_drop: got %b expected 1", bus.overflow); end
    step();
    bus.clr_ovf = 0;
    vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clr: got %b expected 0", bus.overflow); end
    for (int k = 0; k < 8; k++) begin
      int c = 0;
      bus.tx_ready = 1; #1;
      while (!bus.trmt && c < 4) begin step(); #1; c++; end
      vectors++; if (bus.trmt !== 1'b1) begin miscompares++; $display("FAIL ovf_drain_trmt%0d: got %b expected 1", k, bus.trmt); end
      vectors++; if (bus.tx_data !== 8'(k + 1)) begin miscompares++; $display("FAIL ovf_drain_data%0d: got %h expected %h", k, bus.tx_data, 8'(k + 1)); end
      step();
      bus.tx_ready = 0;
      step();
    end
    bus.tx_ready = 1;
    step();
    vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL ovf_empty: got %b expected 1", bus.empty); end
  endtask

  task automatic test_push_pop_wrap();
    bus.tx_ready = 0;
    push(8'hA0); push(8'hA1); push(8'hA2);
    bus.tx_ready = 1; bus.wr_en = 1; bus.wr_data = 8'hA3; #1;
    vectors++; if (bus.trmt !== 1'b1) begin miscompares++; $display("FAIL pp_trmt: got %b expected 1", bus.trmt); end
    vectors++; if (bus.tx_data !== 8'hA0) begin miscompares++; $display("FAIL pp_data: got %h expected a0", bus.tx_data); end
    step();
    bus.wr_en = 0;
    vectors++; if (bus.count !== 4'd3) begin miscompares++; $display("FAIL pp_cnt3: got %0d expected 3", bus.count); end
    bus.tx_ready = 0;
    for (int i = 4; i <= 8; i++) push(8'hA0 + 8'(i));
    vectors++; if (bus.count !== 4'd8) begin miscompares++; $display("FAIL pp_cnt8: got %0d expected 8", bus.count); end
    for (int k = 0; k < 8; k++) begin
      int c = 0;
      bus.tx_ready = 1; #1;
      while (!bus.trmt && c < 4) begin step(); #1; c++; end
      vectors++; if (bus.trmt !== 1'b1) begin miscompares++; $display("FAIL pp_drain_trmt%0d: got %b expected 1", k, bus.trmt); end
      vectors++; if (bus.tx_data !== 8'hA1 + 8'(k)) begin miscompares++; $display("FAIL pp_drain_data%0d: got %h expected %h", k, bus.tx_data, 8'hA1 + 8'(k)); end
      step();
      bus.tx_ready = 0;
      step();
    end
    bus.tx_ready = 1;
    step();
    vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL pp_empty: got %b expected 1", bus.empty); end
  endtask

  task automatic test_flush_sending();
    int pulses = 0;
    bus.tx_ready = 0;
    for (int i = 0; i < 6; i++) push(8'hB0 + 8'(i));
    bus.tx_ready = 1; #1;
    vectors++; if (bus.tx_data !== 8'hB0 || bus.trmt !== 1'b1) begin miscompares++; $display("FAIL fl_first: got %h/%b expected b0/1", bus.tx_data, bus.trmt); end
    step();
    bus.tx_ready = 0;
    step();
    vectors++; if (bus.count !== 4'd5) begin miscompares++; $display("FAIL fl_cnt5: got %0d expected 5", bus.count); end
    bus.flush = 1;
    step();
    bus.flush = 0; #1;
    vectors++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin miscompares++; $display("FAIL fl_cleared: got %0d/%b expected 0/1", bus.count, bus.empty); end
    vectors++; if (dut.r_state !== TXQ_SENDING) begin miscompares++; $display("FAIL fl_state: got %0d expected %0d", dut.r_state, TXQ_SENDING); end
    bus.tx_ready = 1;
    for (int c = 0; c < 4; c++) begin step(); #1; if (bus.trmt) pulses++; end
    vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL fl_no_trmt: got %0d expected 0", pulses); end
    vectors++; if (bus.idle !== 1'b1) begin miscompares++; $display("FAIL fl_idle: got %b expected 1", bus.idle); end
  endtask

  task automatic test_flush_trmt_full();
    bus.tx_ready = 0;
    for (int i = 0; i < 8; i++) push(8'hC0 + 8'(i));
    bus.tx_ready = 1; bus.flush = 1; bus.wr_en = 1; bus.wr_data = 8'hCC; #1;
    vectors++; if (bus.trmt !== 1'b1 || bus.tx_data !== 8'hC0) begin miscompares++; $display("FAIL ft_trmt: got %b/%h expected 1/c0", bus.trmt, bus.tx_data); end
    step();
    bus.flush = 0; bus.wr_en = 0;
    vectors++; if (bus.count !== 4'd0) begin miscompares++; $display("FAIL ft_cnt: got %0d expected 0", bus.count); end
    vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL ft_ovf: got %b expected 0", bus.overflow); end
    vectors++; if (dut.r_state !== TXQ_WAIT_ACK) begin miscompares++; $display("FAIL ft_state: got %0d expected %0d", dut.r_state, TXQ_WAIT_ACK); end
    bus.tx_ready = 0; step();
    bus.tx_ready = 1; step();
  endtask

  task automatic test_reset_mid();
    bus.tx_ready = 0;
    for (int i = 0; i < 5; i++) push(8'hD0 + 8'(i));
    bus.tx_ready = 1; step();
    bus.tx_ready = 0; step();
    vectors++; if (bus.count !== 4'd4 || dut.r_state !== TXQ_SENDING) begin miscompares++; $display("FAIL rm_pre: got %0d/%0d expected 4/%0d", bus.count, dut.r_state, TXQ_SENDING); end
    #1 rst = 1'b1;
    #1;
    vectors++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin miscompares++; $display("FAIL rm_cnt: got %0d/%b expected 0/1", bus.count, bus.empty); end
    vectors++; if (bus.trmt !== 1'b0) begin miscompares++; $display("FAIL rm_trmt: got %b expected 0", bus.trmt); end
    vectors++; if (dut.r_state !== TXQ_IDLE) begin miscompares++; $display("FAIL rm_state: got %0d expected %0d", dut.r_state, TXQ_IDLE); end
    step();
    rst = 1'b0; #1;
    vectors++; if (bus.idle !== 1'b0) begin miscompares++; $display("FAIL rm_idle_lo: got %b expected 0", bus.idle); end
    bus.tx_ready = 1; #1;
    vectors++; if (bus.idle !== 1'b1) begin miscompares++; $display("FAIL rm_idle_hi: got %b expected 1", bus.idle); end
    step(); #1;
    vectors++; if (bus.trmt !== 1'b0) begin miscompares++; $display("FAIL rm_no_trmt: got %b expected 0", bus.trmt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_push_pop_wrap();
    test_flush_sending();
    test_flush_trmt_full();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 2..64).
REQ-002 SHALL have port clk, input, 1, single clock for all logic.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port wr_en, input, 1, bus write strobe, one byte per cycle.
REQ-005 SHALL have port wr_data, input, 8, byte to enqueue.
REQ-006 SHALL have port flush, input, 1, discard all queued bytes.
REQ-007 SHALL have port clr_ovf, input, 1, clear the overflow flag.
REQ-008 SHALL have port full, output, 1, count == DEPTH.
REQ-009 SHALL have port empty, output, 1, count == 0.
REQ-010 SHALL have port count, output, $clog2(DEPTH)+1, bytes queued.
REQ-011 SHALL have port overflow, output, 1, sticky dropped-write flag.
REQ-012 SHALL have port idle, output, 1, empty & FSM in IDLE & tx_ready.
REQ-013 SHALL have port trmt, output, 1, start pulse to the transmitter.
REQ-014 SHALL have port tx_data, output, 8, byte presented to the transmitter.
REQ-015 SHALL have port tx_ready, input, 1, transmitter idle indicator (high when the transmitter can accept).

Function
REQ-016 SHALL accept a write when wr_en & !full: store wr_data at wr_ptr, advance wr_ptr modulo DEPTH.
REQ-017 SHALL drop a write when wr_en & full, even if a pop occurs in the same cycle, and set overflow the next cycle.
REQ-018 SHALL clear overflow only on clr_ovf; a simultaneous clr_ovf and dropped write leaves overflow set.
REQ-019 SHALL update count by +1 (push only), -1 (pop only), or 0 (push and pop together, or neither).
REQ-020 SHALL drive tx_data combinationally from the entry at rd_ptr; the value is don't-care when empty.
REQ-021 SHALL implement FSM states IDLE, WAIT_ACK and SENDING.
REQ-022 In IDLE, when !empty & tx_ready, SHALL assert trmt for exactly one cycle, pop the head (advance rd_ptr) in that cycle, and go to WAIT_ACK.
REQ-023 In WAIT_ACK, SHALL hold trmt low and go to SENDING when tx_ready is low; otherwise it stays.
REQ-024 In SENDING, SHALL go to IDLE when tx_ready returns high.
REQ-025 SHALL issue no trmt outside IDLE, so trmt pulses are separated by at least one full transmitter frame.
REQ-026 SHALL allow a trmt the cycle after a write to an empty queue, giving a write-to-trmt latency of 1 cycle.
REQ-027 Flush SHALL zero both pointers and count next cycle, and SHALL NOT change the FSM state or overflow.
REQ-028 Flush together with wr_en SHALL give flush priority, dropping the write without setting overflow.
REQ-029 Flush together with a trmt in IDLE SHALL let that byte transmit, then empty the queue.
REQ-030 SHALL wrap both pointers at DEPTH; full and empty SHALL derive from count, not from pointer compare.
REQ-031 SHALL enter IDLE from any illegal FSM state on the next clock.

Reset
REQ-032 rst SHALL asynchronously set the pointers to 0, count to 0 and overflow to 0, with the FSM in IDLE and trmt at 0.
REQ-033 After reset, outputs SHALL be empty=1, full=0 and idle equal to tx_ready.
REQ-034 Reset mid-frame SHALL abandon queue contents; the transmitter is reset separately.
REQ-035 The storage array SHALL NOT be reset.

Structure
REQ-036 The FSM state typedef and UART_TXQ_DEPTH (8) SHALL live in the shared periph_defines package alongside UART_BAUD_DIV_W.
REQ-037 Storage and pointers SHALL form one sub-module, sync_fifo (parameters WIDTH and DEPTH), with the FSM kept in uart_tx_queue.
REQ-038 The block SHALL connect directly to the UART transmitter trmt, tx_data and tx_ready ports, and SHALL NOT use tx_done.

Verification
REQ-039 Write 0x55, with tx_ready high: trmt one cycle later with tx_data=0x55, count 1->0, then FSM IDLE->WAIT_ACK->SENDING->IDLE.
REQ-040 Write 0x01..0x08 back-to-back with tx_ready low: full=1 at count 8; a ninth write of 0xFF is dropped, overflow=1; bytes emerge in order 0x01..0x08.
REQ-041 Push and pop in the same cycle at count 3: count stays 3; subsequent data order is preserved across pointer wrap.
REQ-042 With 5 queued, assert flush during SENDING: count=0 and empty=1 next cycle; the in-flight frame completes; no further trmt.
REQ-043 Assert rst mid-SENDING with 4 queued: immediately count=0, trmt=0, FSM IDLE; after release, idle=tx_ready.
REQ-044 clr_ovf and a dropped write in the same cycle: overflow stays 1; clr_ovf alone next cycle -> overflow 0.
